// File: rtl/theta_slice_pkg.sv
// Shared constants, lane indexing and FSM state encoding for the theta slice sequencer.
package theta_slice_pkg;

  localparam int SLICE_W = 25;
  localparam int COLS    = 5;
  localparam int ROWS    = 5;

  // Sequencer states: one pass is PRE, DEPTH x RUN, DRAIN, DONE.
  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_PRE   = 3'd1,
    ST_RUN   = 3'd2,
    ST_DRAIN = 3'd3,
    ST_DONE  = 3'd4
  } theta_state_e;

  // Bit position of lane (x,y) inside a 25-bit slice; lane (0,0) is the MSB.
  function automatic int idx(input int x, input int y);
    return SLICE_W - 1 - (x + COLS * y);
  endfunction

  // Five column parities of one slice; bit x holds the XOR of column x.
  function automatic logic [COLS-1:0] col_parity(input logic [SLICE_W-1:0] s);
    logic [COLS-1:0] p;
    p = '0;
    for (int x = 0; x < COLS; x++) begin
      for (int y = 0; y < ROWS; y++) begin
        p[x] = p[x] ^ s[idx(x, y)];
      end
    end
    return p;
  endfunction

endpackage

// File: rtl/theta_slice_ctrl_apply.sv
// Combinational theta kernel for one slice: column parity of the slice and the
// slice mixed with its own parity and the parity of the previous slice.
module theta_slice_apply
  import theta_slice_pkg::*;
(
  input  logic [SLICE_W-1:0] slice_in,
  input  logic [COLS-1:0]    cur_par,
  input  logic [COLS-1:0]    prev_par,
  output logic [SLICE_W-1:0] slice_out,
  output logic [COLS-1:0]    par
);

  // Parity of the incoming slice, also fed back by the caller as cur_par.
  assign par = col_parity(slice_in);

  // Each lane picks up the parity of column x-1 of this slice and column x+1 of slice z-1.
  for (genvar gi = 0; gi < COLS; gi++) begin : g_col
    for (genvar gj = 0; gj < ROWS; gj++) begin : g_row
      assign slice_out[idx(gi, gj)] = slice_in[idx(gi, gj)]
                                    ^ cur_par[(gi + 4) % COLS]
                                    ^ prev_par[(gi + 1) % COLS];
    end
  end

endmodule

// File: rtl/theta_slice_ctrl.sv
// Theta pass sequencer: streams every slice of the state RAM through the theta
// kernel and writes it back in place, carrying the z-1 column parity forward.
module theta_slice_ctrl
  import theta_slice_pkg::*;
#(
  parameter int N     = 25,
  parameter int DEPTH = 64,
  parameter int AW    = 6
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  output logic          busy,
  output logic          done,
  output logic          rd_en,
  output logic [AW-1:0] rd_addr,
  input  logic [N-1:0]  rd_data,
  output logic          wr_en,
  output logic [AW-1:0] wr_addr,
  output logic [N-1:0]  wr_data
);

  localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);

  theta_state_e    state_q, state_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic            rd_en_q, rd_en_d;
  logic [AW-1:0]   rd_addr_q, rd_addr_d;
  logic [AW-1:0]   cnt_q, cnt_d;
  logic            first_q, first_d;
  logic [COLS-1:0] prev_par_q, prev_par_d;

  logic [COLS-1:0] slice_par;
  logic [N-1:0]    mixed;

  theta_slice_apply u_apply (
    .slice_in (rd_data),
    .cur_par  (slice_par),
    .prev_par (prev_par_q),
    .slice_out(mixed),
    .par      (slice_par)
  );

  // Next-state logic; read strobe/address are registered one state ahead so they
  // line up with the state they belong to.
  always_comb begin
    state_d    = state_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    rd_en_d    = rd_en_q;
    rd_addr_d  = rd_addr_q;
    cnt_d      = cnt_q;
    first_d    = first_q;
    prev_par_d = prev_par_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d   = ST_PRE;
          busy_d    = 1'b1;
          rd_en_d   = 1'b1;
          rd_addr_d = LAST;
        end
      end
      ST_PRE: begin
        state_d   = ST_RUN;
        first_d   = 1'b1;
        cnt_d     = '0;
        rd_en_d   = 1'b1;
        rd_addr_d = '0;
      end
      ST_RUN: begin
        // First RUN cycle sees slice DEPTH-1 and only primes the z-1 parity.
        first_d    = 1'b0;
        prev_par_d = slice_par;
        if (cnt_q == LAST) begin
          state_d   = ST_DRAIN;
          rd_en_d   = 1'b0;
          rd_addr_d = '0;
        end else begin
          cnt_d     = cnt_q + AW'(1);
          rd_addr_d = cnt_q + AW'(1);
        end
      end
      ST_DRAIN: begin
        state_d = ST_DONE;
        busy_d  = 1'b0;
        done_d  = 1'b1;
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
        busy_d  = 1'b0;
        rd_en_d = 1'b0;
      end
    endcase
  end

  // Sequencer state register with asynchronous clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      rd_en_q    <= 1'b0;
      rd_addr_q  <= '0;
      cnt_q      <= '0;
      first_q    <= 1'b0;
      prev_par_q <= '0;
    end else begin
      state_q    <= state_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      rd_en_q    <= rd_en_d;
      rd_addr_q  <= rd_addr_d;
      cnt_q      <= cnt_d;
      first_q    <= first_d;
      prev_par_q <= prev_par_d;
    end
  end

  // Write port follows read data by one slice; forced to zero when idle so it never carries X.
  always_comb begin
    wr_en   = 1'b0;
    wr_addr = '0;
    wr_data = '0;
    if (state_q == ST_RUN && !first_q) begin
      wr_en   = 1'b1;
      wr_addr = cnt_q - AW'(1);
      wr_data = mixed;
    end else if (state_q == ST_DRAIN) begin
      wr_en   = 1'b1;
      wr_addr = LAST;
      wr_data = mixed;
    end
  end

  assign busy    = busy_q;
  assign done    = done_q;
  assign rd_en   = rd_en_q;
  assign rd_addr = rd_addr_q;

endmodule

// File: tb/tb_theta_slice_ctrl.sv
// Self-checking bench for theta_slice_ctrl with a behavioural state RAM and a
// column-parity reference model.
module tb_theta_slice_ctrl;

  localparam int N     = 25;
  localparam int DEPTH = 64;
  localparam int AW    = 6;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic          busy, done, rd_en, wr_en;
  logic [AW-1:0] rd_addr, wr_addr;
  logic [N-1:0]  rd_data, wr_data;

  always #5 clk = ~clk;

  theta_slice_ctrl #(.N(N), .DEPTH(DEPTH), .AW(AW)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (start),
    .busy   (busy),
    .done   (done),
    .rd_en  (rd_en),
    .rd_addr(rd_addr),
    .rd_data(rd_data),
    .wr_en  (wr_en),
    .wr_addr(wr_addr),
    .wr_data(wr_data)
  );

  logic [N-1:0] mem      [DEPTH];
  logic [N-1:0] init_mem [DEPTH];
  logic [N-1:0] src_mem  [DEPTH];
  logic [N-1:0] exp_mem  [DEPTH];
  logic         load_req = 1'b0;

  // State RAM: registered read, write port independent of read port.
  always @(posedge clk) begin
    if (load_req) mem <= init_mem;
    else if (wr_en) mem[wr_addr] <= wr_data;
    if (rd_en) rd_data <= mem[rd_addr];
  end

  int n_checks = 0;
  int n_fail   = 0;
  int done_cyc;
  int busy_err;
  logic [AW-1:0] log_addr[$];
  logic [N-1:0]  log_data[$];
  logic [3+2*AW+N:0] rst_obs;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load_ram();
    load_req = 1'b1;
    tick();
    load_req = 1'b0;
    src_mem = init_mem;
  endtask

  // Reference: theta over the whole state from src_mem, straight from the lane equations.
  task automatic compute_expected();
    logic [4:0] c [DEPTH];
    int zp, b;
    for (int z = 0; z < DEPTH; z++) begin
      c[z] = '0;
      for (int x = 0; x < 5; x++)
        for (int y = 0; y < 5; y++)
          c[z][x] = c[z][x] ^ src_mem[z][24 - (x + 5 * y)];
    end
    for (int z = 0; z < DEPTH; z++) begin
      zp = (z + DEPTH - 1) % DEPTH;
      for (int x = 0; x < 5; x++)
        for (int y = 0; y < 5; y++) begin
          b = 24 - (x + 5 * y);
          exp_mem[z][b] = src_mem[z][b] ^ c[z][(x + 4) % 5] ^ c[zp][(x + 1) % 5];
        end
    end
  endtask

  // Issue start at relative cycle 0 and log writes/busy until done or a cycle budget runs out.
  task automatic run_pass(input bit hold, input int rst_cyc);
    log_addr.delete();
    log_data.delete();
    done_cyc = -1;
    busy_err = 0;
    start = 1'b1;
    for (int cyc = 1; cyc <= 150; cyc++) begin
      tick();
      if (hold) start = (cyc != 29);
      else start = 1'b0;
      if (cyc == rst_cyc) begin
        rst_n = 1'b0;
        start = 1'b0;
        #1;
        rst_obs = {busy, done, rd_en, wr_en, rd_addr, wr_addr, wr_data};
        $display("pass: reset asserted at cycle %0d after %0d writes", cyc, log_addr.size());
        return;
      end
      if (busy !== (cyc <= DEPTH + 2)) busy_err++;
      if (wr_en === 1'b1) begin
        log_addr.push_back(wr_addr);
        log_data.push_back(wr_data);
      end
      if (done === 1'b1) begin
        done_cyc = cyc;
        break;
      end
    end
    $display("pass: done at cycle %0d, %0d writes, busy deviations %0d",
             done_cyc, log_addr.size(), busy_err);
  endtask

  task automatic test_reset();
    repeat (3) tick();
    n_checks++;
    if ({busy, done, rd_en, wr_en, rd_addr, wr_addr, wr_data} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: got %h expected 0",
               {busy, done, rd_en, wr_en, rd_addr, wr_addr, wr_data});
    end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_all_zero();
    for (int z = 0; z < DEPTH; z++) init_mem[z] = '0;
    load_ram();
    compute_expected();
    run_pass(1'b0, -1);
    n_checks++;
    if (done_cyc !== DEPTH + 3) begin
      n_fail++; $display("FAIL zero_done_cycle: got %0d expected %0d", done_cyc, DEPTH + 3);
    end
    n_checks++;
    if (busy_err !== 0) begin
      n_fail++; $display("FAIL zero_busy_window: got %0d bad cycles expected 0", busy_err);
    end
    n_checks++;
    if (log_addr.size() !== DEPTH) begin
      n_fail++; $display("FAIL zero_write_count: got %0d expected %0d", log_addr.size(), DEPTH);
    end
    for (int i = 0; i < log_addr.size() && i < DEPTH; i++) begin
      n_checks++;
      if (log_addr[i] !== AW'(i) || log_data[i] !== 25'h0000000) begin
        n_fail++;
        $display("FAIL zero_write[%0d]: got addr %0d data %h expected addr %0d data 0000000",
                 i, log_addr[i], log_data[i], i);
      end
    end
  endtask

  task automatic test_single_lane();
    for (int z = 0; z < DEPTH; z++) init_mem[z] = '0;
    init_mem[0] = 25'h1000000;
    load_ram();
    compute_expected();
    run_pass(1'b0, -1);
    tick();
    n_checks++;
    if (mem[0] !== 25'h1842108 || mem[1] !== 25'h0108421) begin
      n_fail++;
      $display("FAIL lane_slices: got %h %h expected 1842108 0108421", mem[0], mem[1]);
    end
    for (int z = 0; z < DEPTH; z++) begin
      n_checks++;
      if (mem[z] !== exp_mem[z]) begin
        n_fail++; $display("FAIL lane_ram[%0d]: got %h expected %h", z, mem[z], exp_mem[z]);
      end
    end
  endtask

  task automatic test_wrap();
    for (int z = 0; z < DEPTH; z++) init_mem[z] = '0;
    init_mem[DEPTH-1] = 25'h1000000;
    load_ram();
    compute_expected();
    run_pass(1'b0, -1);
    tick();
    n_checks++;
    if (mem[DEPTH-1] !== 25'h1842108 || mem[0] !== 25'h0108421) begin
      n_fail++;
      $display("FAIL wrap_slices: got %h %h expected 1842108 0108421", mem[DEPTH-1], mem[0]);
    end
    for (int z = 0; z < DEPTH; z++) begin
      n_checks++;
      if (mem[z] !== exp_mem[z]) begin
        n_fail++; $display("FAIL wrap_ram[%0d]: got %h expected %h", z, mem[z], exp_mem[z]);
      end
    end
  endtask

  task automatic test_even_column();
    for (int z = 0; z < DEPTH; z++) init_mem[z] = '0;
    init_mem[5] = 25'h1080000;
    load_ram();
    run_pass(1'b0, -1);
    tick();
    for (int z = 0; z < DEPTH; z++) begin
      n_checks++;
      if (mem[z] !== init_mem[z]) begin
        n_fail++; $display("FAIL even_ram[%0d]: got %h expected %h", z, mem[z], init_mem[z]);
      end
    end
  endtask

  task automatic test_random();
    for (int p = 0; p < 4; p++) begin
      for (int z = 0; z < DEPTH; z++) init_mem[z] = N'($urandom);
      load_ram();
      compute_expected();
      run_pass(1'b0, -1);
      n_checks++;
      if (done_cyc !== DEPTH + 3 || log_addr.size() !== DEPTH) begin
        n_fail++;
        $display("FAIL rand_pass%0d: got done %0d writes %0d expected done %0d writes %0d",
                 p, done_cyc, log_addr.size(), DEPTH + 3, DEPTH);
      end
      for (int i = 0; i < log_addr.size() && i < DEPTH; i++) begin
        n_checks++;
        if (log_addr[i] !== AW'(i) || log_data[i] !== exp_mem[i]) begin
          n_fail++;
          $display("FAIL rand_write%0d[%0d]: got addr %0d data %h expected addr %0d data %h",
                   p, i, log_addr[i], log_data[i], i, exp_mem[i]);
        end
      end
      tick();
    end
  endtask

  task automatic test_start_held();
    for (int z = 0; z < DEPTH; z++) init_mem[z] = N'($urandom);
    load_ram();
    compute_expected();
    run_pass(1'b1, -1);
    n_checks++;
    if (done_cyc !== DEPTH + 3 || log_addr.size() !== DEPTH || busy_err !== 0) begin
      n_fail++;
      $display("FAIL held_first: got done %0d writes %0d busy_err %0d expected %0d %0d 0",
               done_cyc, log_addr.size(), busy_err, DEPTH + 3, DEPTH);
    end
    tick();
    n_checks++;
    if (busy !== 1'b0 || rd_en !== 1'b0) begin
      n_fail++; $display("FAIL held_idle_gap: got busy %b rd_en %b expected 0 0", busy, rd_en);
    end
    src_mem = exp_mem;
    compute_expected();
    run_pass(1'b0, -1);
    tick();
    n_checks++;
    if (done_cyc !== DEPTH + 3 || log_addr.size() !== DEPTH) begin
      n_fail++;
      $display("FAIL held_second: got done %0d writes %0d expected %0d %0d",
               done_cyc, log_addr.size(), DEPTH + 3, DEPTH);
    end
    for (int z = 0; z < DEPTH; z++) begin
      n_checks++;
      if (mem[z] !== exp_mem[z]) begin
        n_fail++; $display("FAIL held_ram[%0d]: got %h expected %h", z, mem[z], exp_mem[z]);
      end
    end
  endtask

  task automatic test_reset_mid();
    logic [N-1:0] part [DEPTH];
    for (int z = 0; z < DEPTH; z++) init_mem[z] = N'($urandom);
    load_ram();
    compute_expected();
    run_pass(1'b0, 20);
    n_checks++;
    if (rst_obs !== '0) begin
      n_fail++; $display("FAIL midreset_outputs: got %h expected 0", rst_obs);
    end
    repeat (3) tick();
    // Writes in cycles 3..19 commit addresses 0..16; nothing after reset.
    for (int z = 0; z < DEPTH; z++) part[z] = (z < 17) ? exp_mem[z] : src_mem[z];
    for (int z = 0; z < DEPTH; z++) begin
      n_checks++;
      if (mem[z] !== part[z]) begin
        n_fail++; $display("FAIL midreset_ram[%0d]: got %h expected %h", z, mem[z], part[z]);
      end
    end
    n_checks++;
    if (busy !== 1'b0 || wr_en !== 1'b0) begin
      n_fail++; $display("FAIL midreset_hold: got busy %b wr_en %b expected 0 0", busy, wr_en);
    end
    rst_n = 1'b1;
    tick();
    src_mem = part;
    compute_expected();
    run_pass(1'b0, -1);
    tick();
    n_checks++;
    if (done_cyc !== DEPTH + 3 || log_addr.size() !== DEPTH) begin
      n_fail++;
      $display("FAIL midreset_rerun: got done %0d writes %0d expected %0d %0d",
               done_cyc, log_addr.size(), DEPTH + 3, DEPTH);
    end
    for (int z = 0; z < DEPTH; z++) begin
      n_checks++;
      if (mem[z] !== exp_mem[z]) begin
        n_fail++; $display("FAIL midreset_final[%0d]: got %h expected %h", z, mem[z], exp_mem[z]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_all_zero();
    tick();
    test_single_lane();
    test_wrap();
    test_even_column();
    test_random();
    test_start_held();
    tick();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
